// File: rtl/um_pkt_arbiter.sv
// um_pkt_arbiter: packet-granular 2:1 arbiter for the 134-bit UM packet bus.
// src0 carries forwarded data, src1 carries local reports/beacons. Grants change
// only at packet boundaries. A watchdog closes stalled packets with a discard tail.
// Build option: define UMARB_STRICT_PRIO_EN to make src1 win every tie
// (default build: round-robin).
module um_pkt_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_req,
    output logic             s0_gnt,
    input  logic             s0_data_wr,
    input  logic [133:0]     s0_data,
    input  logic             s0_data_valid,
    input  logic             s0_data_valid_wr,
    input  logic             s1_req,
    output logic             s1_gnt,
    input  logic             s1_data_wr,
    input  logic [133:0]     s1_data,
    input  logic             s1_data_valid,
    input  logic             s1_data_valid_wr,
    input  logic             out_ready,
    output logic             out_data_wr,
    output logic [133:0]     out_data,
    output logic             out_data_valid,
    output logic             out_data_valid_wr,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1, ST_ABORT} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;           // source that finished the previous packet
    logic               owner_q, owner_d;         // source holding the current grant
    logic               head_seen_q, head_seen_d; // a head word has been forwarded
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               s0_gnt_q, s0_gnt_d;
    logic               s1_gnt_q, s1_gnt_d;
    logic               out_wr_q, out_wr_d;
    logic [133:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_valid_wr_q, out_valid_wr_d;
    logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
    logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;

    // Granted-source view of the bus
    logic         g_wr;
    logic [133:0] g_data;
    logic         g_valid;
    logic         g_valid_wr;
    logic         winner;

    assign g_wr       = owner_q ? s1_data_wr       : s0_data_wr;
    assign g_data     = owner_q ? s1_data          : s0_data;
    assign g_valid    = owner_q ? s1_data_valid    : s0_data_valid;
    assign g_valid_wr = owner_q ? s1_data_valid_wr : s0_data_valid_wr;

`ifdef UMARB_STRICT_PRIO_EN
    assign winner = s1_req;
`else
    assign winner = (s0_req && s1_req) ? ~last_q : s1_req;
`endif

    // Next-state and next-output computation for the arbiter FSM
    always_comb begin
        // NOTE: every _d starts from a default so no path leaves a value unassigned,
        // which would otherwise infer a latch.
        state_d        = state_q;
        last_d         = last_q;
        owner_d        = owner_q;
        head_seen_d    = head_seen_q;
        idle_cnt_d     = idle_cnt_q;
        s0_gnt_d       = s0_gnt_q;
        s1_gnt_d       = s1_gnt_q;
        out_wr_d       = 1'b0;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_valid_wr_d = 1'b0;
        pkt_cnt0_d     = pkt_cnt0_q;
        pkt_cnt1_d     = pkt_cnt1_q;
        abort_cnt_d    = abort_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (out_ready && (s0_req || s1_req)) begin
                    owner_d     = winner;
                    state_d     = winner ? ST_GNT1 : ST_GNT0;
                    s0_gnt_d    = ~winner;
                    s1_gnt_d    = winner;
                    idle_cnt_d  = '0;
                    head_seen_d = 1'b0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                out_wr_d       = g_wr;
                out_data_d     = g_data;
                out_valid_d    = g_valid;
                out_valid_wr_d = g_valid_wr;
                if (g_wr) begin
                    idle_cnt_d = '0;
                    if (g_data[133:132] == 2'b10) begin
                        s0_gnt_d = 1'b0;
                        s1_gnt_d = 1'b0;
                        last_d   = owner_q;
                        state_d  = ST_IDLE;
                        if (owner_q) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                        else         pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                    end else if (g_data[133:132] == 2'b01) begin
                        head_seen_d = 1'b1;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
                    s0_gnt_d = 1'b0;
                    s1_gnt_d = 1'b0;
                    state_d  = ST_ABORT;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_ABORT: begin
                // A started packet is closed with an invalid tail so downstream discards it
                if (head_seen_q) begin
                    out_wr_d       = 1'b1;
                    out_data_d     = {2'b10, 132'b0};
                    out_valid_d    = 1'b0;
                    out_valid_wr_d = 1'b1;
                    last_d         = owner_q;
                end
                abort_cnt_d = abort_cnt_q + CNT_W'(1);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all control and datapath flops take the async reset so outputs read
        // 0 the moment rst_n falls, with no partially sent word left on the bus.
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_q         <= 1'b1;
            owner_q        <= 1'b0;
            head_seen_q    <= 1'b0;
            idle_cnt_q     <= '0;
            s0_gnt_q       <= 1'b0;
            s1_gnt_q       <= 1'b0;
            out_wr_q       <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
            pkt_cnt0_q     <= '0;
            pkt_cnt1_q     <= '0;
            abort_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // values, independent of statement order.
            state_q        <= state_d;
            last_q         <= last_d;
            owner_q        <= owner_d;
            head_seen_q    <= head_seen_d;
            idle_cnt_q     <= idle_cnt_d;
            s0_gnt_q       <= s0_gnt_d;
            s1_gnt_q       <= s1_gnt_d;
            out_wr_q       <= out_wr_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            pkt_cnt0_q     <= pkt_cnt0_d;
            pkt_cnt1_q     <= pkt_cnt1_d;
            abort_cnt_q    <= abort_cnt_d;
        end
    end

    assign s0_gnt            = s0_gnt_q;
    assign s1_gnt            = s1_gnt_q;
    assign out_data_wr       = out_wr_q;
    assign out_data          = out_data_q;
    assign out_data_valid    = out_valid_q;
    assign out_data_valid_wr = out_valid_wr_q;
    assign pkt_cnt0          = pkt_cnt0_q;
    assign pkt_cnt1          = pkt_cnt1_q;
    assign abort_cnt         = abort_cnt_q;

endmodule

// File: tb/tb_um_pkt_arbiter.sv
// Testbench for um_pkt_arbiter: random packets through a scoreboard queue, grant
// order predicted from the arbitration rules, watchdog, backpressure and reset cases.
module tb_um_pkt_arbiter;

    localparam int TIMEOUT = 256;
    localparam int CNT_W   = 32;

    logic             clk;
    logic             rst_n;
    logic             s0_req, s0_gnt, s0_data_wr, s0_data_valid, s0_data_valid_wr;
    logic [133:0]     s0_data;
    logic             s1_req, s1_gnt, s1_data_wr, s1_data_valid, s1_data_valid_wr;
    logic [133:0]     s1_data;
    logic             out_ready;
    logic             out_data_wr, out_data_valid, out_data_valid_wr;
    logic [133:0]     out_data;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1, abort_cnt;

    um_pkt_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_req(s0_req), .s0_gnt(s0_gnt), .s0_data_wr(s0_data_wr), .s0_data(s0_data),
        .s0_data_valid(s0_data_valid), .s0_data_valid_wr(s0_data_valid_wr),
        .s1_req(s1_req), .s1_gnt(s1_gnt), .s1_data_wr(s1_data_wr), .s1_data(s1_data),
        .s1_data_valid(s1_data_valid), .s1_data_valid_wr(s1_data_valid_wr),
        .out_ready(out_ready), .out_data_wr(out_data_wr), .out_data(out_data),
        .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {data, valid, valid_wr}
    logic [135:0] sb[$];

    int n_vec = 0;
    int n_err = 0;
    int pend0 = 0;
    int pend1 = 0;
    int last_m = 1;
    int cnt0_m = 0;
    int cnt1_m = 0;
    int abort_m = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Winner of an arbitration given the request levels and the model's pointer
    function automatic int predict(input logic r0, input logic r1);
`ifdef UMARB_STRICT_PRIO_EN
        return r1 ? 1 : 0;
`else
        if (r0 && r1) return (last_m == 1) ? 0 : 1;
        return r1 ? 1 : 0;
`endif
    endfunction

    task automatic drive(input int who, input logic wr, input logic [133:0] d,
                         input logic v, input logic vw);
        if (who == 1) begin
            s1_data_wr = wr; s1_data = d; s1_data_valid = v; s1_data_valid_wr = vw;
        end else begin
            s0_data_wr = wr; s0_data = d; s0_data_valid = v; s0_data_valid_wr = vw;
        end
    endtask

    task automatic update_reqs();
        s0_req = (pend0 > 0);
        s1_req = (pend1 > 0);
    endtask

    task automatic model_reset();
        last_m = 1; cnt0_m = 0; cnt1_m = 0; abort_m = 0;
    endtask

    // Wait for a grant, check the winner, and send one packet of nwords words
    task automatic run_packet(input int nwords, input bit drop_ready, output int waited);
        int           pred;
        int           who;
        logic         ok;
        logic [1:0]   tag;
        logic [131:0] pay;
        logic         v;
        logic         vw;
        pred   = predict(s0_req, s1_req);
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 64) begin
            @(posedge clk); #1;
            waited++;
            if (s0_gnt || s1_gnt) ok = 1'b1;
        end
        if (!ok) begin
            check("grant_timeout", 0, 1);
            return;
        end
        who = s1_gnt ? 1 : 0;
        check("winner", who, pred);
        check("gnt_onehot", {s0_gnt, s1_gnt}, (who == 1) ? 2'b01 : 2'b10);
        if (who == 1) pend1--; else pend0--;
        update_reqs();
        for (int i = 0; i < nwords; i++) begin
            tag = (i == 0) ? 2'b01 : ((i == nwords - 1) ? 2'b10 : 2'b11);
            pay = 132'({$urandom, $urandom, $urandom, $urandom, $urandom});
            v   = 1'($urandom_range(0, 1));
            vw  = (i == nwords - 1);
            if (drop_ready && i == 1) out_ready = 1'b0;
            drive(who, 1'b1, {tag, pay}, v, vw);
            sb.push_back({tag, pay, v, vw});
            @(posedge clk); #1;
            if (i < nwords - 1 && $urandom_range(0, 3) == 0) begin
                drive(who, 1'b0, '0, 1'b0, 1'b0);
                @(posedge clk); #1;
            end
        end
        drive(who, 1'b0, '0, 1'b0, 1'b0);
        check("gnt_low_after_tail", {s0_gnt, s1_gnt}, 2'b00);
        last_m = who;
        if (who == 1) cnt1_m++; else cnt0_m++;
        if (drop_ready) out_ready = 1'b1;
    endtask

    // Monitor: every output word must match the next scoreboard entry
    initial begin
        logic [135:0] got;
        forever begin
            @(negedge clk);
            if (rst_n && out_data_wr) begin
                got = {out_data, out_data_valid, out_data_valid_wr};
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", got);
                end else begin
                    check("out_word", got, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, expected done");
        $fatal(1);
    end

    initial begin
        int waited;
        int gnt_seen;
        logic ok;

        rst_n = 1'b0; out_ready = 1'b1;
        s0_req = 0; s1_req = 0;
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {s0_gnt, s1_gnt, out_data_wr, out_data, out_data_valid,
                                out_data_valid_wr}, '0);
        check("reset_pkt_cnt0", pkt_cnt0, 0);
        check("reset_pkt_cnt1", pkt_cnt1, 0);
        check("reset_abort_cnt", abort_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Tie after reset: alternating grants (strict: all src1 first)
        pend0 = 3; pend1 = 3; update_reqs();
        repeat (6) run_packet(2 + $urandom_range(0, 4), 1'b0, waited);
        check("tie_pkt_cnt0", pkt_cnt0, cnt0_m);
        check("tie_pkt_cnt1", pkt_cnt1, cnt1_m);

        // Single source 4-word packet
        pend0 = 1; update_reqs();
        run_packet(4, 1'b0, waited);
        @(negedge clk);
        check("single_pkt_cnt0", pkt_cnt0, cnt0_m);

        // Watchdog: src1 sends head + middle, then stalls
        pend1 = 1; update_reqs();
        ok = 1'b0; waited = 0;
        while (!ok && waited < 64) begin
            @(posedge clk); #1; waited++;
            if (s1_gnt) ok = 1'b1;
        end
        check("wd_grant_s1", ok, 1'b1);
        pend1 = 0; pend0 = 1; update_reqs();
        drive(1, 1'b1, {2'b01, 132'h1234_5678}, 1'b0, 1'b0);
        sb.push_back({2'b01, 132'h1234_5678, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive(1, 1'b1, {2'b11, 132'hABCD}, 1'b1, 1'b0);
        sb.push_back({2'b11, 132'hABCD, 1'b1, 1'b0});
        @(posedge clk); #1;
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        sb.push_back({2'b10, 132'b0, 1'b0, 1'b1});
        waited = 0;
        while (s1_gnt && waited < TIMEOUT + 20) begin
            @(posedge clk); #1; waited++;
        end
        check("wd_gnt_dropped", s1_gnt, 1'b0);
        check("wd_stall_len_ok", (waited >= TIMEOUT - 1) && (waited <= TIMEOUT + 1), 1'b1);
        last_m = 1; abort_m++;
        run_packet(3, 1'b0, waited);
        check("wd_abort_cnt", abort_cnt, abort_m);

        // Backpressure: no grant while out_ready is low
        out_ready = 1'b0;
        pend0 = 1; pend1 = 1; update_reqs();
        gnt_seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (s0_gnt || s1_gnt) gnt_seen++;
        end
        check("bp_no_grant", gnt_seen, 0);
        out_ready = 1'b1;
        run_packet(5, 1'b1, waited);
        check("bp_grant_latency_ok", waited <= 2, 1'b1);
        run_packet(3, 1'b0, waited);
        check("bp_pkt_cnt0", pkt_cnt0, cnt0_m);
        check("bp_pkt_cnt1", pkt_cnt1, cnt1_m);

        // Reset asserted while word 3 of a packet is due
        pend1 = 1; update_reqs();
        ok = 1'b0; waited = 0;
        while (!ok && waited < 64) begin
            @(posedge clk); #1; waited++;
            if (s1_gnt) ok = 1'b1;
        end
        check("rst_grant_s1", ok, 1'b1);
        pend1 = 0; update_reqs();
        drive(1, 1'b1, {2'b01, 132'h55}, 1'b0, 1'b0);
        sb.push_back({2'b01, 132'h55, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive(1, 1'b1, {2'b11, 132'h66}, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {s0_gnt, s1_gnt, out_data_wr, out_data, out_data_valid,
                                  out_data_valid_wr, pkt_cnt0, pkt_cnt1, abort_cnt}, '0);
        sb.delete();
        drive(1, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        pend0 = 1; pend1 = 1; update_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_packet(3, 1'b0, waited);
        run_packet(4, 1'b0, waited);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_pkt_cnt0", pkt_cnt0, cnt0_m);
        check("final_pkt_cnt1", pkt_cnt1, cnt1_m);
        check("final_abort_cnt", abort_cnt, abort_m);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
